// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared op codes, state encoding and step limit for the shift sequencer
package shift_seq_pkg;

    localparam int DATA_W   = 32;
    localparam int STEP_MAX = 2;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step_32.sv
// rtl/shift_step_32.sv - combinational 1/2-bit step shifter; SHIFT_SEQ_ARITH_EN enables sign fill for op 10
module shift_step_32
    import shift_seq_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_op,
    input  logic [1:0]  i_step,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SLL: o_data = i_data << i_step;
            OP_SRL: o_data = i_data >> i_step;
            OP_SRA: begin
`ifdef SHIFT_SEQ_ARITH_EN
                o_data = $unsigned($signed(i_data) >>> i_step);
`else
                // Without the arithmetic option op 10 degrades to a logical right shift.
                o_data = i_data >> i_step;
`endif
            end
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative SLL/SRL/SRA sequencer, two bits per cycle; SHIFT_SEQ_ARITH_EN selects sign fill
module shift_sequencer #(
    parameter int DATA_W   = shift_seq_pkg::DATA_W,
    parameter int STEP_MAX = shift_seq_pkg::STEP_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [4:0]        shamt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] data_o
);

    import shift_seq_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        r_count;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_work;
    logic [DATA_W-1:0] r_data_o;

    logic              w_direct;
    logic              w_last;
    logic [1:0]        w_step;
    logic [DATA_W-1:0] w_shifted;

    // Zero shift and pass-through skip SHIFT and complete straight from IDLE.
    assign w_direct = (shamt_i == 5'd0) || (op_i == OP_PASS);
    assign w_last   = (r_count <= 5'(STEP_MAX));
    assign w_step   = w_last ? r_count[1:0] : 2'(STEP_MAX);

    shift_step_32 u_step (
        .i_data (r_work),
        .i_op   (r_op),
        .i_step (w_step),
        .o_data (w_shifted)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_next = w_direct ? DONE : SHIFT;
            SHIFT:   if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_count  <= 5'd0;
            r_op     <= OP_SLL;
            r_work   <= '0;
            r_data_o <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_work  <= data_i;
                        r_op    <= op_i;
                        r_count <= shamt_i;
                        if (w_direct) r_data_o <= data_i;
                    end
                end
                SHIFT: begin
                    r_work  <= w_shifted;
                    r_count <= r_count - {3'b000, w_step};
                    if (w_last) r_data_o <= w_shifted;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (r_state != IDLE);
    assign done_o = (r_state == DONE);
    assign data_o = r_data_o;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized self-checking bench for shift_sequencer against a one-shot shift model
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i    = 2'b00;
    logic [31:0] data_i  = 32'h0;
    logic [4:0]  shamt_i = 5'd0;
    wire         busy_o;
    wire         done_o;
    wire  [31:0] data_o;

    int checks   = 0;
    int failures = 0;

    shift_sequencer dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .data_i  (data_i),
        .shamt_i (shamt_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int sh);
        case (op)
            2'b00: return d << sh;
            2'b01: return d >> sh;
`ifdef SHIFT_SEQ_ARITH_EN
            2'b10: return 32'($signed(d) >>> sh);
`else
            2'b10: return d >> sh;
`endif
            default: return d;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input int sh);
        if (op == 2'b11 || sh == 0) return 0;
        return (sh + 1) / 2;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        start_i = 1'b1;
        op_i    = op;
        data_i  = d;
        shamt_i = sh;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        op_i    = 2'($urandom_range(0, 3));
        data_i  = $urandom;
        shamt_i = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_done(output int n, output int busy_gaps);
        n = 0;
        busy_gaps = 0;
        while (done_o !== 1'b1 && n < 40) begin
            if (busy_o !== 1'b1) busy_gaps++;
            @(posedge clk_i); #1;
            n++;
        end
        if (busy_o !== 1'b1) busy_gaps++;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b data=%h required busy=0 done=0 data=00000000", busy_o, done_o, data_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
        logic [31:0] t_dat [6] = '{32'h4, 32'h10, 32'h80000000, 32'h80000000, 32'hDEADBEEF, 32'hDEADBEEF};
        logic [4:0]  t_sh  [6] = '{5'd2, 5'd3, 5'd31, 5'd4, 5'd0, 5'd9};
        int          t_lat [6] = '{1, 2, 16, 2, 0, 0};
`ifdef SHIFT_SEQ_ARITH_EN
        logic [31:0] t_exp [6] = '{32'h10, 32'h80, 32'h1, 32'hF8000000, 32'hDEADBEEF, 32'hDEADBEEF};
`else
        logic [31:0] t_exp [6] = '{32'h10, 32'h80, 32'h1, 32'h08000000, 32'hDEADBEEF, 32'hDEADBEEF};
`endif
        int n, gaps;
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_dat[i], t_sh[i]);
            wait_done(n, gaps);
            checks++;
            if (n !== t_lat[i] || gaps !== 0) begin
                failures++;
                $display("FAIL directed_latency[%0d] cycles=%0d busy_gaps=%0d required cycles=%0d busy_gaps=0", i, n, gaps, t_lat[i]);
            end
            checks++;
            if (data_o !== t_exp[i]) begin
                failures++;
                $display("FAIL directed_result[%0d] data=%h required %h", i, data_o, t_exp[i]);
            end
            @(posedge clk_i); #1;
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || data_o !== t_exp[i]) begin
                failures++;
                $display("FAIL directed_after_done[%0d] done=%b busy=%b data=%h required done=0 busy=0 data=%h", i, done_o, busy_o, data_o, t_exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] d, exp;
        logic [4:0]  sh;
        int n, gaps;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            sh = 5'($urandom_range(0, 31));
            exp = ref_shift(op, d, int'(sh));
            issue(op, d, sh);
            wait_done(n, gaps);
            checks++;
            if (n !== ref_lat(op, int'(sh)) || gaps !== 0) begin
                failures++;
                $display("FAIL random_latency[%0d] op=%0d sh=%0d cycles=%0d gaps=%0d required cycles=%0d gaps=0", i, op, sh, n, gaps, ref_lat(op, int'(sh)));
            end
            checks++;
            if (data_o !== exp) begin
                failures++;
                $display("FAIL random_result[%0d] op=%0d d=%h sh=%0d data=%h required %h", i, op, d, sh, data_o, exp);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a, b;
        int n, gaps;
        a = $urandom;
        b = 32'h00001234;
        start_i = 1'b1;
        op_i    = OP_SRL;
        data_i  = a;
        shamt_i = 5'd10;
        @(posedge clk_i); #1;
        op_i    = OP_SLL;
        data_i  = b;
        shamt_i = 5'd4;
        wait_done(n, gaps);
        checks++;
        if (n !== 5 || data_o !== ref_shift(OP_SRL, a, 10)) begin
            failures++;
            $display("FAIL busy_first cycles=%0d data=%h required cycles=5 data=%h", n, data_o, ref_shift(OP_SRL, a, 10));
        end
        @(posedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_in_done busy=%b required 0", busy_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_second_accept busy=%b required 1", busy_o);
        end
        start_i = 1'b0;
        wait_done(n, gaps);
        checks++;
        if (n !== 2 || data_o !== ref_shift(OP_SLL, b, 4)) begin
            failures++;
            $display("FAIL busy_second cycles=%0d data=%h required cycles=2 data=%h", n, data_o, ref_shift(OP_SLL, b, 4));
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        int n, gaps;
        issue(OP_SRL, $urandom | 32'h1, 5'd31);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_shift busy=%b done=%b data=%h required busy=0 done=0 data=00000000", busy_o, done_o, data_o);
        end
        rst_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (done_o !== 1'b0 || busy_o !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_no_done active_cycles=%0d required 0", seen);
        end
        issue(OP_SLL, 32'h1, 5'd5);
        wait_done(n, gaps);
        checks++;
        if (n !== 3 || gaps !== 0 || data_o !== 32'h20) begin
            failures++;
            $display("FAIL reset_recover cycles=%0d gaps=%0d data=%h required cycles=3 gaps=0 data=00000020", n, gaps, data_o);
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
